// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// State encoding (3 decodes as IDLE) and default operand width.
package shift_add_multiplier_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_cla.sv
// CLA_generate: N-bit carry-generate/propagate adder.
// Ports: x, y, cin in; sum, cout out (purely combinational).
module CLA_generate #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g    = x & y;
  assign p    = x ^ y;
  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_carry
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-and-add multiplier.
// Ports: clk, reset, start, a, b in; busy, done, product out.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [CNT_W-1:0]   count;
  logic               last;
  logic [2*WIDTH-1:0] shifted;

  CLA_generate #(.N(WIDTH)) u_add (
    .x    (acc),
    .y    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign last = (count == CNT_W'(WIDTH - 1));

  // cout lands in the top of acc after the right shift
  assign shifted = mq[0]
    ? {cout, sum, mq[WIDTH-1:1]}
    : {1'b0, acc, mq[WIDTH-1:1]};

  always_comb begin
    state_n = ST_IDLE;
    case (state)
      ST_IDLE: state_n = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_n = last ? ST_DONE : ST_RUN;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      count   <= '0;
    end else begin
      busy <= (state_n != ST_IDLE);
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            count <= '0;
          end
        end
        ST_RUN: begin
          acc   <= shifted[2*WIDTH-1:WIDTH];
          mq    <= shifted[WIDTH-1:0];
          count <= count + CNT_W'(1);
          if (last) product <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier at WIDTH=8 and WIDTH=16.
// Directed cases plus random operands against a*b.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        st8, st16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] p8;
  logic [31:0] p16;

  int n_cmp = 0;
  int n_err = 0;
  int nd8 = 0;
  int nd16 = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(8)) u_m8 (
    .clk(clk), .reset(reset), .start(st8),
    .a(a8), .b(b8), .busy(busy8),
    .done(done8), .product(p8)
  );

  shift_add_multiplier #(.WIDTH(16)) u_m16 (
    .clk(clk), .reset(reset), .start(st16),
    .a(a16), .b(b16), .busy(busy16),
    .done(done16), .product(p16)
  );

  always @(posedge clk) begin
    if (done8)  nd8  <= nd8 + 1;
    if (done16) nd16 <= nd16 + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Runs one op; returns result, edges to done,
  // busy-sample count and whether product held.
  task automatic do_op(input bit wide,
                       input logic [15:0] x,
                       input logic [15:0] y,
                       input logic [31:0] prev,
                       output logic [31:0] res,
                       output int lat,
                       output int bcnt,
                       output bit held);
    int w;
    w = wide ? 16 : 8;
    lat = 0;
    bcnt = 0;
    held = 1'b1;
    if (wide) begin
      st16 = 1'b1; a16 = x; b16 = y;
    end else begin
      st8 = 1'b1; a8 = x[7:0]; b8 = y[7:0];
    end
    @(posedge clk); #1;
    st8 = 1'b0;
    st16 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    if (wide ? busy16 : busy8) bcnt++;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (wide ? busy16 : busy8) bcnt++;
      if (wide ? done16 : done8) begin
        lat = k;
        break;
      end
      if (k < w) begin
        if ((wide ? p16 : {16'd0, p8}) != prev)
          held = 1'b0;
      end
    end
    if (lat == 0) chk("timeout", 32'd0, 32'd1);
    res = wide ? p16 : {16'd0, p8};
  endtask

  logic [31:0] res, prev;
  int lat, bcnt, dcnt, nd_base;
  bit held;
  logic [15:0] x, y;

  initial begin
    reset = 1'b1;
    st8 = 1'b0; st16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_prod", {16'd0, p8}, 32'd0);
    chk("rst_prod16", p16, 32'd0);

    do_op(0, 16'd13, 16'd11, 32'd0, res, lat, bcnt, held);
    chk("13x11", res, 32'd143);
    chk("lat", lat, 32'd9);
    chk("busy_cyc", bcnt, 32'd9);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done8}, 32'd0);

    do_op(0, 16'hFF, 16'hFF, 32'd0, res, lat, bcnt, held);
    chk("ffxff", res, 32'hFE01);
    do_op(0, 16'h00, 16'hA5, 32'd0, res, lat, bcnt, held);
    chk("0xa5", res, 32'd0);
    chk("lat0a", lat, 32'd9);
    do_op(0, 16'h5A, 16'h00, 32'd0, res, lat, bcnt, held);
    chk("5ax0", res, 32'd0);
    chk("lat0b", lat, 32'd9);

    // start re-pulsed at edges 3 and 9 must be ignored
    a8 = 8'd3; b8 = 8'd4; st8 = 1'b1;
    dcnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
      st8 = (k + 1 == 3) || (k + 1 == 9);
      if (st8) begin a8 = 8'd9; b8 = 8'd9; end
    end
    chk("repulse_done", dcnt, 32'd1);
    chk("repulse_prod", {16'd0, p8}, 32'd12);

    // reset during iteration 4 aborts the op
    a8 = 8'd200; b8 = 8'd200; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    chk("abort_done", dcnt, 32'd0);
    chk("abort_prod", {16'd0, p8}, 32'd0);
    chk("abort_busy", {31'd0, busy8}, 32'd0);

    do_op(0, 16'd7, 16'd6, 32'd0, res, lat, bcnt, held);
    chk("7x6", res, 32'd42);
    // back-to-back: start in the cycle after done
    do_op(0, 16'h80, 16'h02, 32'd42, res, lat, bcnt, held);
    chk("b2b", res, 32'h100);
    chk("b2b_held", {31'd0, held}, 32'd1);
    chk("b2b_lat", lat, 32'd9);

    do_op(1, 16'hFFFF, 16'hFFFF, p16, res, lat, bcnt, held);
    chk("w16_max", res, 32'hFFFE0001);
    chk("w16_lat", lat, 32'd17);
    chk("w16_busy", bcnt, 32'd17);

    @(posedge clk); #1;
    nd_base = nd8;
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom_range(0, 255));
      y = 16'($urandom_range(0, 255));
      if (i % 97 == 0) x = 16'hFF;
      prev = {16'd0, p8};
      do_op(0, x, y, prev, res, lat, bcnt, held);
      chk("rnd8", res, 32'(x) * 32'(y));
      chk("rnd8_lat", lat, 32'd9);
    end
    @(posedge clk); #1;
    chk("rnd8_dones", nd8 - nd_base, 32'd1000);

    nd_base = nd16;
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 89 == 0) y = 16'd0;
      prev = p16;
      do_op(1, x, y, prev, res, lat, bcnt, held);
      chk("rnd16", res, 32'(x) * 32'(y));
      chk("rnd16_lat", lat, 32'd17);
    end
    @(posedge clk); #1;
    chk("rnd16_dones", nd16 - nd_base, 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
